ofifo_drain: RTL and testbench

Output-side drain engine for the corelet. It pops finished partial-sum rows from the corelet OFIFO by driving the OFIFO read-enable (the `inst[6]` bit of the corelet instruction) whenever `ofifo_valid` is high. Each popped row is written, with optional per-lane ReLU, into the psum SRAM at consecutive addresses from a programmed base. It is the consumer end of the OFIFO interface and runs under the top-level controller, which starts it once per output tile and waits for `done`.

---
 rtl/ofifo_drain.sv | 176 +++++++++++++++++
 tb/tb_ofifo_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain.sv
// ---------------------------------------------------------------------------
// ofifo_drain
//
// Output-side drain engine for the corelet. Once started, it pops finished
// partial-sum rows from the OFIFO whenever the head row is valid. It writes
// each popped row, with optional per-lane ReLU, to the psum SRAM at
// consecutive addresses starting from a latched base address.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         drain request, honoured only in IDLE
//   base_addr     first SRAM address of the tile (latched on start)
//   num_words     rows to drain, 0..2^addr_bw (latched on start)
//   relu_en       per-lane ReLU enable (latched on start)
//   ofifo_valid   OFIFO head row valid
//   ofifo_output  OFIFO head row, lane k at [k*psum_bw +: psum_bw]
//   ofifo_rd      OFIFO pop (combinational)
//   mem_cen       SRAM chip enable, active-low, registered
//   mem_wen       SRAM write enable, active-low, registered
//   mem_addr      SRAM address, registered
//   mem_d         SRAM write data, registered
//   busy          high while in DRAIN or DONE
//   done          one-cycle completion pulse
//   wr_count      rows written so far in the current tile
// ---------------------------------------------------------------------------
module ofifo_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw:0]         num_words,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_output,
    output logic                     ofifo_rd,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [col*psum_bw-1:0]   mem_d,
    output logic                     busy,
    output logic                     done,
    output logic [addr_bw:0]         wr_count
);

    localparam int DW = col * psum_bw;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_r;
    logic [addr_bw-1:0]  base_r;
    logic [addr_bw:0]    num_r;
    logic                relu_r;
    logic [addr_bw:0]    issued_r;
    logic                pop_s;
    logic                last_s;

    // Zero every negative lane when enabled; lanes are independent, no width change.
    function automatic logic [DW-1:0] relu_row(input logic [DW-1:0] row, input logic en);
        logic [DW-1:0] res;
        res = row;
        for (int k = 0; k < col; k++) begin
            if (en && row[k*psum_bw + psum_bw - 1]) begin
                res[k*psum_bw +: psum_bw] = {psum_bw{1'b0}};
            end else begin
                res[k*psum_bw +: psum_bw] = row[k*psum_bw +: psum_bw];
            end
        end
        return res;
    endfunction

    // Pop decision: only in DRAIN, only while rows of this tile remain to be taken.
    always_comb begin
        pop_s  = 1'b0;
        last_s = 1'b0;
        if ((state_r == DRAIN) && ofifo_valid && (issued_r < num_r)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if ((issued_r + {{addr_bw{1'b0}}, 1'b1}) == num_r) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    assign ofifo_rd = pop_s;

    // FSM, SRAM write pipeline stage and write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            base_r   <= {addr_bw{1'b0}};
            num_r    <= {(addr_bw+1){1'b0}};
            relu_r   <= 1'b0;
            issued_r <= {(addr_bw+1){1'b0}};
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_addr <= {addr_bw{1'b0}};
            mem_d    <= {DW{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= {(addr_bw+1){1'b0}};
        end else begin
            // A pop presents its write one cycle later; otherwise hold address/data.
            if (pop_s) begin
                mem_cen  <= 1'b0;
                mem_wen  <= 1'b0;
                mem_addr <= base_r + issued_r[addr_bw-1:0];
                mem_d    <= relu_row(ofifo_output, relu_r);
                issued_r <= issued_r + {{addr_bw{1'b0}}, 1'b1};
            end else begin
                mem_cen  <= 1'b1;
                mem_wen  <= 1'b1;
            end

            // Count each write actually presented to the SRAM.
            if (!mem_cen && !mem_wen) begin
                wr_count <= wr_count + {{addr_bw{1'b0}}, 1'b1};
            end else begin
                wr_count <= wr_count;
            end

            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_r   <= base_addr;
                        num_r    <= num_words;
                        relu_r   <= relu_en;
                        issued_r <= {(addr_bw+1){1'b0}};
                        wr_count <= {(addr_bw+1){1'b0}};
                        busy     <= 1'b1;
                        if (num_words == {(addr_bw+1){1'b0}}) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DRAIN: begin
                    busy <= 1'b1;
                    if (pop_s && last_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_drain.sv
// ---------------------------------------------------------------------------
// tb_ofifo_drain
//
// Directed self-checking bench for ofifo_drain. A small OFIFO model supplies
// rows from a table and advances on each ofifo_rd. Each cycle, inputs are
// changed 1 ns after the rising edge and outputs are sampled 2 ns after it.
// ---------------------------------------------------------------------------
module tb_ofifo_drain;

    logic          clk;
    logic          reset;
    logic          start;
    logic [10:0]   base_addr;
    logic [11:0]   num_words;
    logic          relu_en;
    logic          ofifo_valid;
    logic [127:0]  ofifo_output;
    logic          ofifo_rd;
    logic          mem_cen;
    logic          mem_wen;
    logic [10:0]   mem_addr;
    logic [127:0]  mem_d;
    logic          busy;
    logic          done;
    logic [11:0]   wr_count;

    int            total;
    int            bad;

    // OFIFO model
    logic [127:0]  rows [0:7];
    logic [3:0]    rp;
    logic [3:0]    nrows;
    logic          vmask;
    logic          fifo_clr;
    int            pop_cnt;

    assign ofifo_valid  = vmask && (rp < nrows);
    assign ofifo_output = rows[rp[2:0]];

    ofifo_drain #(.col(8), .psum_bw(16), .addr_bw(11)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .relu_en      (relu_en),
        .ofifo_valid  (ofifo_valid),
        .ofifo_output (ofifo_output),
        .ofifo_rd     (ofifo_rd),
        .mem_cen      (mem_cen),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_d        (mem_d),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rp      <= 4'd0;
            pop_cnt <= 0;
        end else if (ofifo_rd === 1'b1) begin
            rp      <= rp + 4'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo(input logic [3:0] n);
        vmask    = 1'b0;
        nrows    = n;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        total++; if ({ofifo_rd, mem_cen, mem_wen, busy, done} !== 5'b01100) begin bad++; $display("FAIL rst_hold ctl got=%b want=01100", {ofifo_rd, mem_cen, mem_wen, busy, done}); end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            total++; if ({ofifo_rd, mem_cen, mem_wen, busy, done} !== 5'b01100) begin bad++; $display("FAIL rst_rel ctl cyc%0d got=%b want=01100", i, {ofifo_rd, mem_cen, mem_wen, busy, done}); end
            total++; if (mem_addr !== 11'h000) begin bad++; $display("FAIL rst_rel addr got=%h want=000", mem_addr); end
            total++; if (mem_d !== 128'h0) begin bad++; $display("FAIL rst_rel data got=%h want=0", mem_d); end
            total++; if (wr_count !== 12'd0) begin bad++; $display("FAIL rst_rel wr_count got=%0d want=0", wr_count); end
        end
    endtask

    task automatic test_stream();
        logic exp_rd, exp_wr, exp_done, exp_busy;
        load_fifo(4'd5);
        tick();
        start = 1'b1; base_addr = 11'h010; num_words = 12'd4; relu_en = 1'b0; vmask = 1'b1;
        #1;
        total++; if (ofifo_rd !== 1'b0) begin bad++; $display("FAIL stream_idle_rd got=%b want=0", ofifo_rd); end
        for (int i = 1; i <= 6; i++) begin
            tick(); start = 1'b0; #1;
            exp_rd   = (i <= 4);
            exp_wr   = (i >= 2) && (i <= 5);
            exp_done = (i == 5);
            exp_busy = (i <= 5);
            total++; if (ofifo_rd !== exp_rd) begin bad++; $display("FAIL stream_rd cyc%0d got=%b want=%b", i, ofifo_rd, exp_rd); end
            total++; if ({mem_cen, mem_wen} !== (exp_wr ? 2'b00 : 2'b11)) begin bad++; $display("FAIL stream_en cyc%0d got=%b want_wr=%b", i, {mem_cen, mem_wen}, exp_wr); end
            if (exp_wr) begin
                total++; if (mem_addr !== 11'h010 + 11'(i - 2)) begin bad++; $display("FAIL stream_addr cyc%0d got=%h want=%h", i, mem_addr, 11'h010 + 11'(i - 2)); end
                total++; if (mem_d !== rows[i - 2]) begin bad++; $display("FAIL stream_data cyc%0d got=%h want=%h", i, mem_d, rows[i - 2]); end
            end
            total++; if (done !== exp_done) begin bad++; $display("FAIL stream_done cyc%0d got=%b want=%b", i, done, exp_done); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL stream_busy cyc%0d got=%b want=%b", i, busy, exp_busy); end
        end
        total++; if (wr_count !== 12'd4) begin bad++; $display("FAIL stream_wr_count got=%0d want=4", wr_count); end
        total++; if (pop_cnt !== 4) begin bad++; $display("FAIL stream_pops got=%0d want=4", pop_cnt); end
    endtask

    task automatic test_relu();
        logic [15:0]  inl [8];
        logic [15:0]  exl [8];
        logic [127:0] expv;
        inl = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001, 16'hFFF0, 16'h1234, 16'h8001};
        exl = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h1234, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            rows[0][k*16 +: 16] = inl[k];
            expv[k*16 +: 16]    = exl[k];
        end
        load_fifo(4'd1);
        tick();
        start = 1'b1; base_addr = 11'h123; num_words = 12'd1; relu_en = 1'b1; vmask = 1'b1;
        #1;
        tick(); start = 1'b0; #1;
        total++; if (ofifo_rd !== 1'b1) begin bad++; $display("FAIL relu_rd got=%b want=1", ofifo_rd); end
        tick(); #1;
        total++; if ({mem_cen, mem_wen, done} !== 3'b001) begin bad++; $display("FAIL relu_ctl got=%b want=001", {mem_cen, mem_wen, done}); end
        total++; if (mem_addr !== 11'h123) begin bad++; $display("FAIL relu_addr got=%h want=123", mem_addr); end
        total++; if (mem_d !== expv) begin bad++; $display("FAIL relu_data got=%h want=%h", mem_d, expv); end
        tick(); #1;
        total++; if ({busy, wr_count} !== {1'b0, 12'd1}) begin bad++; $display("FAIL relu_end busy=%b wr_count=%0d want 0/1", busy, wr_count); end
    endtask

    task automatic test_stall_wrap();
        logic        vpat [9];
        int          widx [9];
        logic [10:0] wa   [3];
        logic        exp_rd;
        vpat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        widx = '{-1, -1, 0, -1, -1, 1, -1, 2, -1};
        wa   = '{11'h7FE, 11'h7FF, 11'h000};
        load_fifo(4'd5);
        tick();
        start = 1'b1; base_addr = 11'h7FE; num_words = 12'd3; relu_en = 1'b0; vmask = 1'b0;
        #1;
        for (int i = 1; i <= 8; i++) begin
            tick(); start = 1'b0; vmask = vpat[i]; #1;
            exp_rd = (i <= 6) ? vpat[i] : 1'b0;
            total++; if (ofifo_rd !== exp_rd) begin bad++; $display("FAIL stall_rd cyc%0d got=%b want=%b", i, ofifo_rd, exp_rd); end
            total++; if ({mem_cen, mem_wen} !== ((widx[i] >= 0) ? 2'b00 : 2'b11)) begin bad++; $display("FAIL stall_en cyc%0d got=%b", i, {mem_cen, mem_wen}); end
            if (widx[i] >= 0) begin
                total++; if (mem_addr !== wa[widx[i]]) begin bad++; $display("FAIL stall_addr cyc%0d got=%h want=%h", i, mem_addr, wa[widx[i]]); end
                total++; if (mem_d !== rows[widx[i]]) begin bad++; $display("FAIL stall_data cyc%0d got=%h want=%h", i, mem_d, rows[widx[i]]); end
            end
            total++; if (done !== (i == 7)) begin bad++; $display("FAIL stall_done cyc%0d got=%b", i, done); end
        end
        total++; if ({busy, wr_count} !== {1'b0, 12'd3}) begin bad++; $display("FAIL stall_end busy=%b wr_count=%0d want 0/3", busy, wr_count); end
        total++; if (pop_cnt !== 3) begin bad++; $display("FAIL stall_pops got=%0d want=3", pop_cnt); end
    endtask

    task automatic test_start_handling();
        logic exp_wr;
        load_fifo(4'd5);
        tick();
        start = 1'b1; base_addr = 11'h200; num_words = 12'd3; relu_en = 1'b0; vmask = 1'b1;
        #1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            start = (i == 2);
            if (i == 2) begin
                base_addr = 11'h050; num_words = 12'd7;
            end
            #1;
            exp_wr = (i >= 2) && (i <= 4);
            total++; if (ofifo_rd !== (i <= 3)) begin bad++; $display("FAIL sh_rd cyc%0d got=%b", i, ofifo_rd); end
            if (exp_wr) begin
                total++; if (mem_addr !== 11'h200 + 11'(i - 2)) begin bad++; $display("FAIL sh_addr cyc%0d got=%h want=%h", i, mem_addr, 11'h200 + 11'(i - 2)); end
                total++; if (mem_d !== rows[i - 2]) begin bad++; $display("FAIL sh_data cyc%0d got=%h want=%h", i, mem_d, rows[i - 2]); end
            end
            total++; if ({done, busy} !== {(i == 4), (i <= 4)}) begin bad++; $display("FAIL sh_state cyc%0d done_busy=%b", i, {done, busy}); end
        end
        total++; if ({wr_count, 32'(pop_cnt)} !== {12'd3, 32'd3}) begin bad++; $display("FAIL sh_counts wr_count=%0d pops=%0d want 3/3", wr_count, pop_cnt); end
        // zero-length tile
        tick();
        start = 1'b1; base_addr = 11'h3AA; num_words = 12'd0; vmask = 1'b1;
        #1;
        tick(); start = 1'b0; #1;
        total++; if ({done, busy, ofifo_rd, mem_cen, mem_wen} !== 5'b11011) begin bad++; $display("FAIL zero_done got=%b want=11011", {done, busy, ofifo_rd, mem_cen, mem_wen}); end
        tick(); #1;
        total++; if ({done, busy, mem_cen, wr_count} !== {3'b001, 12'd0}) begin bad++; $display("FAIL zero_end got done_busy_cen=%b wr_count=%0d", {done, busy, mem_cen}, wr_count); end
        total++; if (pop_cnt !== 3) begin bad++; $display("FAIL zero_pops got=%0d want=3", pop_cnt); end
    endtask

    task automatic test_reset_mid();
        load_fifo(4'd8);
        tick();
        start = 1'b1; base_addr = 11'h300; num_words = 12'd6; relu_en = 1'b0; vmask = 1'b1;
        #1;
        for (int i = 1; i <= 3; i++) begin
            tick(); start = 1'b0; #1;
        end
        total++; if ({mem_cen, mem_addr, wr_count} !== {1'b0, 11'h301, 12'd1}) begin bad++; $display("FAIL rmid_pre cen=%b addr=%h wr_count=%0d", mem_cen, mem_addr, wr_count); end
        tick(); reset = 1'b1; #1;
        tick(); reset = 1'b0; #1;
        total++; if ({busy, done, ofifo_rd, mem_cen, mem_wen} !== 5'b00011) begin bad++; $display("FAIL rmid_idle got=%b want=00011", {busy, done, ofifo_rd, mem_cen, mem_wen}); end
        total++; if (wr_count !== 12'd0) begin bad++; $display("FAIL rmid_wr_count got=%0d want=0", wr_count); end
        tick(); #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rmid_nodone got=%b want=00", {busy, done}); end
        // fresh tile after reset
        load_fifo(4'd4);
        tick();
        start = 1'b1; base_addr = 11'h040; num_words = 12'd2; vmask = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            tick(); start = 1'b0; #1;
            if ((i == 2) || (i == 3)) begin
                total++; if ({mem_cen, mem_addr} !== {1'b0, 11'h040 + 11'(i - 2)}) begin bad++; $display("FAIL rmid_new_addr cyc%0d cen=%b addr=%h", i, mem_cen, mem_addr); end
                total++; if (mem_d !== rows[i - 2]) begin bad++; $display("FAIL rmid_new_data cyc%0d got=%h want=%h", i, mem_d, rows[i - 2]); end
            end
            total++; if (done !== (i == 3)) begin bad++; $display("FAIL rmid_new_done cyc%0d got=%b", i, done); end
        end
        total++; if ({busy, wr_count} !== {1'b0, 12'd2}) begin bad++; $display("FAIL rmid_new_end busy=%b wr_count=%0d want 0/2", busy, wr_count); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 11'h000;
        num_words = 12'd0;
        relu_en   = 1'b0;
        vmask     = 1'b1;
        nrows     = 4'd5;
        fifo_clr  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                rows[i][k*16 +: 16] = 16'h9000 + 16'(i * 16 + k);
            end
        end
        test_reset();
        test_stream();
        test_relu();
        test_stall_wrap();
        test_start_handling();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
